// File: rtl/rv32_regfile_np_if.sv
// rv32_regfile_np_if: decode/writeback-side bundle of the RV32 register file
interface rv32_regfile_np_if #(
    parameter int XLEN  = 32,
    parameter int NREAD = 2
);
    logic                    stall_in;
    logic                    writeback_flush_in;
    logic [5*NREAD-1:0]      rs_in;
    logic [4:0]              rd_in;
    logic                    rd_write_in;
    logic [XLEN-1:0]         rd_value_in;
    logic                    clear_req_in;
    logic [XLEN*NREAD-1:0]   rs_value_out;
    logic                    busy_out;

    modport master (
        output stall_in, writeback_flush_in, rs_in, rd_in, rd_write_in, rd_value_in, clear_req_in,
        input  rs_value_out, busy_out
    );

    modport slave (
        input  stall_in, writeback_flush_in, rs_in, rd_in, rd_write_in, rd_value_in, clear_req_in,
        output rs_value_out, busy_out
    );
endinterface

// File: rtl/rv32_regfile_np.sv
// rv32_regfile_np: parametrised RV32 integer register file with write bypass and clear sequencer
module rv32_regfile_np #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1
) (
    input logic              clk,
    input logic              reset,
    rv32_regfile_np_if.slave bus
);
    localparam int         AW   = $clog2(NREGS);
    localparam logic [5:0] NR   = 6'(NREGS);
    localparam logic [4:0] LAST = 5'(NREGS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state, state_nxt;
    logic [4:0]      cnt, cnt_nxt;
    logic [4:0]      rs_q [NREAD];
    logic [XLEN-1:0] regs [NREGS];
    logic            wr_en;

    // clear sequencer state and counter; reset restarts the clear from x1
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= CLEAR;
            cnt   <= 5'd1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end

    // next state: walk x1..x(NREGS-1) while clearing, accept a clear request only when idle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == CLEAR) begin
            cnt_nxt   = cnt + 5'd1;
            state_nxt = (cnt == LAST) ? IDLE : CLEAR;
        end else if (bus.clear_req_in) begin
            state_nxt = CLEAR;
            cnt_nxt   = 5'd1;
        end
    end

    // outputs: busy flag, write qualification and per-port read mux with optional bypass
    always_comb begin
        bus.busy_out     = (state == CLEAR);
        wr_en            = bus.rd_write_in && !bus.writeback_flush_in && bus.rd_in != 5'd0 &&
                           {1'b0, bus.rd_in} < NR && state == IDLE;
        bus.rs_value_out = '0;
        for (int k = 0; k < NREAD; k++)
            bus.rs_value_out[XLEN*k +: XLEN] =
                (rs_q[k] == 5'd0 || {1'b0, rs_q[k]} >= NR || state == CLEAR) ? '0 :
                (BYPASS != 0 && wr_en && bus.rd_in == rs_q[k]) ? bus.rd_value_in :
                regs[rs_q[k][AW-1:0]];
    end

    // read address latches, held while the pipeline stalls
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            for (int k = 0; k < NREAD; k++)
                rs_q[k] <= 5'd0;
        end else if (!bus.stall_in) begin
            for (int k = 0; k < NREAD; k++)
                rs_q[k] <= bus.rs_in[5*k +: 5];
        end

    // register array: the clear sequencer owns the write port while busy; x0 is never stored
    always_ff @(posedge clk)
        if (state == CLEAR)
            regs[cnt[AW-1:0]] <= '0;
        else if (wr_en)
            regs[bus.rd_in[AW-1:0]] <= bus.rd_value_in;
endmodule

// File: tb/tb_rv32_regfile_np.sv
// tb_rv32_regfile_np: directed checks of the register file in bypass, non-bypass and RV32E/4-port builds
module tb_rv32_regfile_np;
    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   na, nb, nc;

    rv32_regfile_np_if #(.XLEN(32), .NREAD(2)) ifa ();
    rv32_regfile_np_if #(.XLEN(32), .NREAD(2)) ifb ();
    rv32_regfile_np_if #(.XLEN(32), .NREAD(4)) ifc ();

    rv32_regfile_np #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    rv32_regfile_np #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
    rv32_regfile_np #(.XLEN(32), .NREGS(16), .NREAD(4), .BYPASS(1)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

    assign ifb.stall_in           = ifa.stall_in;
    assign ifb.writeback_flush_in = ifa.writeback_flush_in;
    assign ifb.rs_in              = ifa.rs_in;
    assign ifb.rd_in              = ifa.rd_in;
    assign ifb.rd_write_in        = ifa.rd_write_in;
    assign ifb.rd_value_in        = ifa.rd_value_in;
    assign ifb.clear_req_in       = ifa.clear_req_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] v, input logic flush);
        ifa.rd_in              = a;
        ifa.rd_value_in        = v;
        ifa.rd_write_in        = 1'b1;
        ifa.writeback_flush_in = flush;
    endtask

    task automatic nowr;
        ifa.rd_write_in        = 1'b0;
        ifa.writeback_flush_in = 1'b0;
    endtask

    task automatic count_busy;
        na = 0;
        nb = 0;
        nc = 0;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (!ifa.busy_out && na == 0) na = i;
            if (!ifb.busy_out && nb == 0) nb = i;
            if (!ifc.busy_out && nc == 0) nc = i;
            if (i == 5) chk("read_during_clear", ifa.rs_value_out[31:0], 32'h0);
        end
    endtask

    initial begin
        reset = 1'b1;
        ifa.stall_in = 0; ifa.writeback_flush_in = 0; ifa.rs_in = '0; ifa.rd_in = '0;
        ifa.rd_write_in = 0; ifa.rd_value_in = '0; ifa.clear_req_in = 0;
        ifc.stall_in = 0; ifc.writeback_flush_in = 0; ifc.rs_in = '0; ifc.rd_in = '0;
        ifc.rd_write_in = 0; ifc.rd_value_in = '0; ifc.clear_req_in = 0;
        repeat (3) tick;
        chk("reset_busy_a", 32'(ifa.busy_out), 32'd1);
        chk("reset_busy_c", 32'(ifc.busy_out), 32'd1);
        chk("reset_out_a", ifa.rs_value_out[31:0], 32'h0);
        chk("reset_out_c", ifc.rs_value_out[127:96], 32'h0);
        reset = 1'b0;
        count_busy;
        chk("clear_len_a", 32'(na), 32'd31);
        chk("clear_len_b", 32'(nb), 32'd31);
        chk("clear_len_c", 32'(nc), 32'd15);

        for (int a = 0; a < 32; a++) begin
            ifa.rs_in = {5'(31 - a), 5'(a)};
            tick;
            chk("cleared_p0", ifa.rs_value_out[31:0], 32'h0);
            chk("cleared_p1", ifa.rs_value_out[63:32], 32'h0);
        end

        ifa.rs_in = {5'd0, 5'd5};
        tick;
        wr(5'd5, 32'hDEADBEEF, 1'b0);
        #1;
        chk("bypass_same_cycle", ifa.rs_value_out[31:0], 32'hDEADBEEF);
        chk("nobypass_same_cycle", ifb.rs_value_out[31:0], 32'h0);
        tick;
        nowr;
        #1;
        chk("bypass_after", ifa.rs_value_out[31:0], 32'hDEADBEEF);
        chk("nobypass_after", ifb.rs_value_out[31:0], 32'hDEADBEEF);

        ifa.rs_in = {5'd31, 5'd0};
        tick;
        wr(5'd31, 32'hCAFEF00D, 1'b0);
        tick;
        nowr;
        #1;
        chk("x31_p1", ifb.rs_value_out[63:32], 32'hCAFEF00D);

        wr(5'd0, 32'h1234, 1'b0);
        #1;
        chk("x0_bypass", ifa.rs_value_out[31:0], 32'h0);
        tick;
        nowr;
        #1;
        chk("x0_read_a", ifa.rs_value_out[31:0], 32'h0);
        chk("x0_read_b", ifb.rs_value_out[31:0], 32'h0);

        ifa.rs_in = {5'd0, 5'd7};
        tick;
        wr(5'd7, 32'h55, 1'b1);
        #1;
        chk("flush_bypass", ifa.rs_value_out[31:0], 32'h0);
        tick;
        nowr;
        #1;
        chk("flush_a", ifa.rs_value_out[31:0], 32'h0);
        chk("flush_b", ifb.rs_value_out[31:0], 32'h0);

        wr(5'd9, 32'hA5, 1'b0);
        tick;
        wr(5'd3, 32'h33, 1'b0);
        tick;
        nowr;
        ifa.rs_in = {5'd9, 5'd0};
        tick;
        chk("stall_pre", ifa.rs_value_out[63:32], 32'hA5);
        ifa.stall_in = 1'b1;
        ifa.rs_in = {5'd3, 5'd0};
        tick;
        chk("stall_hold_a", ifa.rs_value_out[63:32], 32'hA5);
        chk("stall_hold_b", ifb.rs_value_out[63:32], 32'hA5);
        wr(5'd9, 32'hB6, 1'b0);
        #1;
        chk("stall_wr_bypass", ifa.rs_value_out[63:32], 32'hB6);
        chk("stall_wr_nobypass", ifb.rs_value_out[63:32], 32'hA5);
        tick;
        nowr;
        #1;
        chk("stall_wr_after", ifb.rs_value_out[63:32], 32'hB6);
        ifa.stall_in = 1'b0;
        #1;
        chk("unstall_before_edge", ifa.rs_value_out[63:32], 32'hB6);
        tick;
        chk("unstall_switch", ifa.rs_value_out[63:32], 32'h33);

        ifa.rs_in = {5'd12, 5'd10};
        tick;
        ifa.clear_req_in = 1'b1;
        wr(5'd10, 32'h77, 1'b0);
        #1;
        chk("clrreq_bypass", ifa.rs_value_out[31:0], 32'h77);
        tick;
        ifa.clear_req_in = 1'b0;
        wr(5'd12, 32'h99, 1'b0);
        chk("clrreq_busy", 32'(ifa.busy_out), 32'd1);
        na = 0;
        for (int i = 1; i <= 40 && na == 0; i++) begin
            tick;
            if (!ifa.busy_out) na = i;
            if (i == 5) chk("clr_read_zero", ifa.rs_value_out[31:0], 32'h0);
        end
        nowr;
        chk("clrreq_len", 32'(na), 32'd31);
        #1;
        chk("clr_x10", ifa.rs_value_out[31:0], 32'h0);
        chk("clr_x12_a", ifa.rs_value_out[63:32], 32'h0);
        chk("clr_x12_b", ifb.rs_value_out[63:32], 32'h0);
        ifa.rs_in = {5'd3, 5'd9};
        tick;
        chk("clr_x9", ifa.rs_value_out[31:0], 32'h0);
        chk("clr_x3", ifa.rs_value_out[63:32], 32'h0);

        ifa.clear_req_in = 1'b1;
        tick;
        ifa.clear_req_in = 1'b0;
        repeat (9) tick;
        reset = 1'b1;
        #1;
        chk("midclr_reset_busy", 32'(ifa.busy_out), 32'd1);
        tick;
        reset = 1'b0;
        count_busy;
        chk("midclr_len_a", 32'(na), 32'd31);
        chk("midclr_len_b", 32'(nb), 32'd31);
        chk("midclr_len_c", 32'(nc), 32'd15);

        ifc.rd_in = 5'd3;
        ifc.rd_value_in = 32'h3;
        ifc.rd_write_in = 1'b1;
        tick;
        ifc.rs_in = {4{5'd20}};
        ifc.rd_in = 5'd20;
        ifc.rd_value_in = 32'hFF;
        tick;
        ifc.rd_write_in = 1'b0;
        #1;
        chk("e_x20_read", ifc.rs_value_out[31:0], 32'h0);
        ifc.rs_in = {4{5'd3}};
        tick;
        chk("e_p0", ifc.rs_value_out[31:0], 32'h3);
        chk("e_p1", ifc.rs_value_out[63:32], 32'h3);
        chk("e_p2", ifc.rs_value_out[95:64], 32'h3);
        chk("e_p3", ifc.rs_value_out[127:96], 32'h3);
        ifc.rs_in = {5'd0, 5'd20, 5'd4, 5'd3};
        tick;
        chk("e_mix_p0", ifc.rs_value_out[31:0], 32'h3);
        chk("e_mix_x4", ifc.rs_value_out[63:32], 32'h0);
        chk("e_mix_x20", ifc.rs_value_out[95:64], 32'h0);
        chk("e_mix_x0", ifc.rs_value_out[127:96], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rv32_regfile_np.md
# rv32_regfile_np

Parametrised integer register file for the RV32 core: a generalised successor of the two-read/one-write file. It adds a configurable register count (RV32I/RV32E), a configurable number of read ports, optional same-cycle write-to-read bypass, and a hardware clear sequencer that zeroes the array after reset or on request. It sits between decode (read addresses) and writeback (write port), and is read in the execute stage.

## Interface
- XLEN, 32: data width of each register.
- NREGS, 32: number of architectural registers, 32 or 16. x0 is always included.
- NREAD, 2: number of read ports, 1..4.
- BYPASS, 1: when 1, a write in the current cycle is forwarded to matching read ports.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall_in  in  1  holds all latched read addresses.
- writeback_flush_in  in  1  suppresses the write this cycle.
- rs_in  in  5*NREAD  read addresses; port k uses bits [5k+4:5k].
- rd_in  in  5  write address.
- rd_write_in  in  1  write request.
- rd_value_in  in  XLEN  write data.
- clear_req_in  in  1  single-cycle pulse; starts a clear sequence.
- rs_value_out  out  XLEN*NREAD  read data; port k uses bits [XLEN*k+XLEN-1:XLEN*k].
- busy_out  out  1  high while a clear is in progress; the pipeline must stall.

## Operation
- **Read address latch:**
  - On each clk edge with stall_in=0, each port latches its rs_in field into rs_q[k].
  - With stall_in=1, rs_q holds.
  - Latching continues during clear.
- **Read data, per port:**
  - If rs_q[k]=0 or rs_q[k]>=NREGS, output 0.
  - Otherwise, if busy_out=1, output 0.
  - Otherwise, if BYPASS=1 and a write commits this cycle with rd_in==rs_q[k], output rd_value_in.
  - Otherwise, output regs[rs_q[k]].
  - This logic is combinational from rs_q and the write port.
- **Write commit:**
  - A write commits at the clk edge when rd_write_in=1, writeback_flush_in=0, rd_in!=0, rd_in<NREGS, and the FSM is in IDLE.
  - Writes that fail these conditions are dropped silently.
- **Clear FSM, states IDLE and CLEAR:**
  - Reset forces CLEAR with cnt=1.
  - In CLEAR, each cycle writes regs[cnt]=0 and increments cnt. When cnt==NREGS-1, that register is written and the FSM goes to IDLE.
  - In IDLE, clear_req_in=1 moves the FSM to CLEAR with cnt=1. A write committing in the same cycle is still performed and is then overwritten by the clear.
  - clear_req_in is ignored while in CLEAR.
- busy_out is 1 exactly when the state is CLEAR.
- x0 is never stored. Reads of x0 return 0 by the address check above.
- Reads of the same address on several ports in the same cycle all return identical data.

## Timing
- **Reset values:**
  - State CLEAR, cnt=1, busy_out=1, every rs_q=0, every rs_value_out=0.
  - Array contents are undefined until the clear completes.
- **Clear duration:** busy_out falls NREGS-1 rising edges after reset deasserts, i.e. 31 cycles for NREGS=32 and 15 for NREGS=16.
- **clear_req_in:** sampled in IDLE at edge t; busy_out=1 from t until edge t+NREGS-1.
- **Reset mid-clear:** asynchronously restarts the sequence at cnt=1.
- **Write-to-read latency:**
  - BYPASS=1: 0 cycles (visible in the same cycle as the commit).
  - BYPASS=0: 1 cycle (visible after the commit edge).
- **Read address to data:** 1 edge (rs_in to rs_q), then combinational.
- **Stall with writes:** writes are independent of stall_in. A write to a held rs_q address updates the output after the edge, or in the same cycle with bypass.
- **Simultaneous events:**
  - Flush with write: the write is dropped.
  - Write to rd_in>=NREGS: dropped. For NREGS=16, rd_in=20 has no effect.

## Test plan
- **Reset and clear:** pulse reset, then release. busy_out=1 for exactly 31 cycles; afterwards all 32 addresses, read on both ports, return 0.
- **Write then read:** write x5=0xDEADBEEF, with rs_in port0=5 latched.
  - BYPASS=1: port0 shows 0xDEADBEEF in the commit cycle.
  - BYPASS=0: port0 shows 0xDEADBEEF from the next cycle.
- **x0 and flush:**
  - Write x0=0x1234: reads of x0 return 0.
  - Write x7=0x55 with writeback_flush_in=1: x7 still reads 0.
- **Stall hold:** latch rs port1=9 holding 0xA5, then assert stall_in and present rs_in port1=3. Port1 keeps 0xA5 until stall_in drops, then switches to regs[3] one edge later.
- **Clear request with concurrent write:**
  - Pulse clear_req_in together with a write of x10=0x77. busy_out=1 for 31 cycles, during which writes and reads are suppressed (reads return 0).
  - After the clear, x10 reads 0.
  - Assert reset at cycle 10 of the clear: the sequence restarts and busy_out=1 for 31 cycles after reset releases.
- **NREGS=16, NREAD=4:**
  - Clear lasts 15 cycles.
  - Write x20 is dropped, and a read of x20 returns 0.
  - All four ports read x3=0x3 in the same cycle with identical data.
